// File: rtl/wb_arbiter.sv
// Round-robin Wishbone B4 classic arbiter: several masters share one master
// port toward intercon. A grant is held for a whole bus tenancy (CYC high),
// the granted master's signals are muxed onto the bus, and ACK/ERR are
// routed back to it. A watchdog aborts cycles that no slave terminates.

module wb_arbiter #(
   parameter int MASTERS_NUM = 2,
   parameter int ADR_WIDTH   = 32,
   parameter int DAT_WIDTH   = 32,
   parameter int SEL_WIDTH   = 4,
   parameter int TIMEOUT     = 255
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   // master side
   input  logic [MASTERS_NUM-1:0]           m2a_cyc_i,
   input  logic [MASTERS_NUM-1:0]           m2a_stb_i,
   input  logic [MASTERS_NUM-1:0]           m2a_we_i,
   input  logic [MASTERS_NUM*ADR_WIDTH-1:0] m2a_adr_i,
   input  logic [MASTERS_NUM*DAT_WIDTH-1:0] m2a_dat_i,
   input  logic [MASTERS_NUM*SEL_WIDTH-1:0] m2a_sel_i,
   output logic [MASTERS_NUM-1:0]           a2m_ack_o,
   output logic [MASTERS_NUM-1:0]           a2m_err_o,
   output logic [DAT_WIDTH-1:0]             a2m_dat_o,
   // intercon side
   output logic                             a2s_cyc_o,
   output logic                             a2s_stb_o,
   output logic                             a2s_we_o,
   output logic [ADR_WIDTH-1:0]             a2s_adr_o,
   output logic [DAT_WIDTH-1:0]             a2s_dat_o,
   output logic [SEL_WIDTH-1:0]             a2s_sel_o,
   input  logic                             s2a_ack_i,
   input  logic                             s2a_err_i,
   input  logic [DAT_WIDTH-1:0]             s2a_dat_i,
   // status
   output logic [MASTERS_NUM-1:0]           grant_o
);

   localparam int IDX_W = $clog2(MASTERS_NUM);
   // A disabled watchdog still keeps a 1-bit counter so the logic stays legal.
   localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   // Expiry is detected on the stalled beat that would bring the count to
   // TIMEOUT, so the abort follows exactly TIMEOUT unanswered STB cycles.
   localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_ABORT = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [MASTERS_NUM-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]        last_q, last_d;
   logic [WD_W-1:0]         wdog_q, wdog_d;
   logic [WD_W-1:0]         wdog_inc;

   logic [IDX_W-1:0]        win_idx;
   logic                    win_found;
   int                      rr_sum;

   logic                    sel_cyc;
   logic                    sel_stb;
   logic                    sel_we;
   logic [ADR_WIDTH-1:0]    sel_adr;
   logic [DAT_WIDTH-1:0]    sel_dat;
   logic [SEL_WIDTH-1:0]    sel_sel;

   logic                    busy;
   logic                    abort;
   logic                    stall;
   logic                    expire;

   assign busy  = (state_q == ST_BUSY);
   assign abort = (state_q == ST_ABORT);

   // Round-robin search: first requesting master after the last winner, wrapping.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no path leaves
      // it unassigned; otherwise synthesis infers a latch to hold the old value.
      win_idx   = last_q;
      win_found = 1'b0;
      rr_sum    = 0;
      for (int i = 1; i <= MASTERS_NUM; i++) begin
         rr_sum = int'(last_q) + i;
         if (rr_sum >= MASTERS_NUM) begin
            rr_sum = rr_sum - MASTERS_NUM;
         end
         if (!win_found && m2a_cyc_i[IDX_W'(rr_sum)]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(rr_sum);
         end
      end
   end

   // One-hot AND-OR mux selecting the granted master's request signals.
   always_comb begin
      sel_cyc = 1'b0;
      sel_stb = 1'b0;
      sel_we  = 1'b0;
      sel_adr = '0;
      sel_dat = '0;
      sel_sel = '0;
      for (int k = 0; k < MASTERS_NUM; k++) begin
         if (grant_q[k]) begin
            sel_cyc = m2a_cyc_i[k];
            sel_stb = m2a_stb_i[k];
            sel_we  = m2a_we_i[k];
            sel_adr = m2a_adr_i[k*ADR_WIDTH +: ADR_WIDTH];
            sel_dat = m2a_dat_i[k*DAT_WIDTH +: DAT_WIDTH];
            sel_sel = m2a_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
         end
      end
   end

   // A beat is stalled while the granted master strobes and nobody terminates it.
   // An ack or err in the expiry cycle therefore suppresses the abort.
   assign stall    = busy && sel_stb && !s2a_ack_i && !s2a_err_i;
   assign expire   = (TIMEOUT != 0) && stall && (wdog_q == WD_LAST);
   assign wdog_inc = (wdog_q == {WD_W{1'b1}}) ? wdog_q : wdog_q + 1'b1;

   // Next-state, grant and watchdog update.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      wdog_d  = '0;
      case (state_q)
         ST_IDLE: begin
            if (|m2a_cyc_i) begin
               state_d          = ST_BUSY;
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               last_d           = win_idx;
            end
         end
         ST_BUSY: begin
            // Release is checked first: a CYC drop beats a simultaneous expiry.
            if (!sel_cyc) begin
               state_d = ST_IDLE;
               grant_d = '0;
            end else if (expire) begin
               state_d = ST_ABORT;
            end else if (stall) begin
               wdog_d = wdog_inc;
            end
         end
         ST_ABORT: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State register; master 0 wins first after reset because last starts at N-1.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         last_q  <= IDX_W'(MASTERS_NUM - 1);
         wdog_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the values
         // from before this edge, independent of statement order.
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         wdog_q  <= wdog_d;
      end
   end

   // Bus side: granted master passes straight through while BUSY, quiet otherwise.
   assign a2s_cyc_o = busy & sel_cyc;
   assign a2s_stb_o = busy & sel_stb;
   assign a2s_we_o  = busy & sel_we;
   assign a2s_adr_o = busy ? sel_adr : '0;
   assign a2s_dat_o = busy ? sel_dat : '0;
   assign a2s_sel_o = busy ? sel_sel : '0;

   // Master side: terminations go only to the granted master; the abort cycle
   // forces ERR toward it. Read data is shared and qualified by each ACK.
   assign a2m_ack_o = busy ? (grant_q & {MASTERS_NUM{s2a_ack_i}}) : '0;
   assign a2m_err_o = busy  ? (grant_q & {MASTERS_NUM{s2a_err_i}}) :
                      abort ? grant_q : '0;
   assign a2m_dat_o = s2a_dat_i;
   assign grant_o   = grant_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter (3 masters, watchdog of 8 cycles).
// A tenancy-level model (owner, last winner, stalled-beat count) predicts the
// outputs; a negedge process compares every cycle, and directed sequences
// pin the model with hand-computed values before a randomized run.

module tb_wb_arbiter;

   localparam int N  = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int TO = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [N-1:0]      cyc = '0;
   logic [N-1:0]      stb = '0;
   logic [N-1:0]      we  = '0;
   logic [N*AW-1:0]   adr = '0;
   logic [N*DW-1:0]   wdat = '0;
   logic [N*SW-1:0]   sel = '0;
   logic              s_ack = 1'b0;
   logic              s_err = 1'b0;
   logic [DW-1:0]     s_dat = '0;

   logic [N-1:0]      a2m_ack_o;
   logic [N-1:0]      a2m_err_o;
   logic [DW-1:0]     a2m_dat_o;
   logic              a2s_cyc_o;
   logic              a2s_stb_o;
   logic              a2s_we_o;
   logic [AW-1:0]     a2s_adr_o;
   logic [DW-1:0]     a2s_dat_o;
   logic [SW-1:0]     a2s_sel_o;
   logic [N-1:0]      grant_o;

   int checks = 0;
   int errors = 0;

   wb_arbiter #(
      .MASTERS_NUM (N),
      .ADR_WIDTH   (AW),
      .DAT_WIDTH   (DW),
      .SEL_WIDTH   (SW),
      .TIMEOUT     (TO)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .m2a_cyc_i (cyc),
      .m2a_stb_i (stb),
      .m2a_we_i  (we),
      .m2a_adr_i (adr),
      .m2a_dat_i (wdat),
      .m2a_sel_i (sel),
      .a2m_ack_o (a2m_ack_o),
      .a2m_err_o (a2m_err_o),
      .a2m_dat_o (a2m_dat_o),
      .a2s_cyc_o (a2s_cyc_o),
      .a2s_stb_o (a2s_stb_o),
      .a2s_we_o  (a2s_we_o),
      .a2s_adr_o (a2s_adr_o),
      .a2s_dat_o (a2s_dat_o),
      .a2s_sel_o (a2s_sel_o),
      .s2a_ack_i (s_ack),
      .s2a_err_i (s_err),
      .s2a_dat_i (s_dat),
      .grant_o   (grant_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic bit_at(input logic [N-1:0] v, input int k);
      logic [N-1:0] t;
      t = v >> k;
      return t[0];
   endfunction

   function automatic logic [AW-1:0] adr_of(input int k);
      logic [N*AW-1:0] t;
      t = adr >> (k * AW);
      return t[AW-1:0];
   endfunction

   function automatic logic [DW-1:0] dat_of(input int k);
      logic [N*DW-1:0] t;
      t = wdat >> (k * DW);
      return t[DW-1:0];
   endfunction

   function automatic logic [SW-1:0] sel_of(input int k);
      logic [N*SW-1:0] t;
      t = sel >> (k * SW);
      return t[SW-1:0];
   endfunction

   // ---------------- behavioural model ----------------
   // owner: master holding the bus (-1 none); aborting: the one ERR cycle
   // after a timeout; stalled: consecutive strobed beats nobody answered.
   int m_owner   = -1;
   int m_last    = N - 1;
   int m_stalled = 0;
   bit m_abort   = 1'b0;
   int pick;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_owner   <= -1;
         m_last    <= N - 1;
         m_stalled <= 0;
         m_abort   <= 1'b0;
      end else if (m_abort) begin
         m_abort <= 1'b0;
         m_owner <= -1;
      end else if (m_owner < 0) begin
         if (cyc != '0) begin
            pick = -1;
            for (int i = 1; i <= N; i++) begin
               if (pick < 0 && bit_at(cyc, (m_last + i) % N)) pick = (m_last + i) % N;
            end
            m_owner <= pick;
            m_last  <= pick;
         end
      end else if (!bit_at(cyc, m_owner)) begin
         m_owner   <= -1;
         m_stalled <= 0;
      end else if (bit_at(stb, m_owner) && !s_ack && !s_err) begin
         if (m_stalled + 1 == TO) begin
            m_abort   <= 1'b1;
            m_stalled <= 0;
         end else begin
            m_stalled <= m_stalled + 1;
         end
      end else begin
         m_stalled <= 0;
      end
   end

   // Compare process: expected outputs from model state and current inputs.
   always @(negedge clk) begin
      logic [N-1:0] e_grant, e_ack, e_err;
      logic [70:0]  e_bus;
      e_grant = '0;
      e_ack   = '0;
      e_err   = '0;
      e_bus   = '0;
      if (!rst && m_owner >= 0) begin
         e_grant = N'(1) << m_owner;
         if (m_abort) begin
            e_err = e_grant;
         end else begin
            e_bus = {bit_at(cyc, m_owner), bit_at(stb, m_owner), bit_at(we, m_owner),
                     adr_of(m_owner), dat_of(m_owner), sel_of(m_owner)};
            if (s_ack) e_ack = e_grant;
            if (s_err) e_err = e_grant;
         end
      end
      check("cmp_grant", grant_o, e_grant);
      check("cmp_bus", {a2s_cyc_o, a2s_stb_o, a2s_we_o, a2s_adr_o, a2s_dat_o, a2s_sel_o}, e_bus);
      check("cmp_ack", a2m_ack_o, e_ack);
      check("cmp_err", a2m_err_o, e_err);
      check("cmp_rdat", a2m_dat_o, s_dat);
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      cyc = '0; stb = '0; we = '0; adr = '0; wdat = '0; sel = '0;
      s_ack = 1'b0; s_err = 1'b0; s_dat = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      repeat (2) tick();
      rst = 1'b0;
   endtask

   logic [N-1:0] seq_exp [5];
   logic [N-1:0] seq_got [$];
   logic [N-1:0] g, prev, acked;
   int           idle_run;
   int           stb_cnt;
   bit           got_err;

   initial begin
      seq_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};

      // Single request from master 1 and mid-cycle reset.
      do_reset();
      cyc = 3'b010; stb = 3'b010; we = 3'b010;
      adr[AW +: AW]  = 32'h1111_0000;
      wdat[DW +: DW] = 32'hCAFE_0001;
      sel[SW +: SW]  = 4'hA;
      tick();
      check("t2_grant", grant_o, 3'b010);
      check("t2_adr", a2s_adr_o, 32'h1111_0000);
      s_ack = 1'b1;
      s_dat = 32'hBEEF_0002;
      #1;
      check("t2_ack", a2m_ack_o, 3'b010);
      check("t2_rdat", a2m_dat_o, 32'hBEEF_0002);
      #1;
      rst = 1'b1;
      #1;
      check("t1_rst_grant", grant_o, 3'b000);
      check("t1_rst_cyc", a2s_cyc_o, 1'b0);
      check("t1_rst_ack", a2m_ack_o, 3'b000);
      tick();

      // Round-robin order with single-beat tenancies.
      do_reset();
      cyc = 3'b111; stb = 3'b111; s_ack = 1'b1;
      prev = '0;
      idle_run = 0;
      for (int c = 0; c < 80 && seq_got.size() < 5; c++) begin
         @(negedge clk);
         g = grant_o;
         acked = a2m_ack_o;
         if (g != '0 && prev == '0) begin
            if (seq_got.size() > 0) check("t3_idle_gap", idle_run, 1);
            seq_got.push_back(g);
            idle_run = 0;
         end
         if (g == '0) idle_run++;
         prev = g;
         @(posedge clk);
         #1;
         cyc = 3'b111 & ~acked;
         stb = cyc;
      end
      check("t3_count", seq_got.size(), 5);
      for (int i = 0; i < 5; i++) begin
         if (i < seq_got.size()) check("t3_order", seq_got[i], seq_exp[i]);
      end

      // Locked burst from master 2 while master 0 waits.
      do_reset();
      cyc = 3'b100; stb = 3'b100;
      tick();
      check("t4_grant2", grant_o, 3'b100);
      cyc = 3'b101; stb = 3'b101;
      for (int b = 0; b < 4; b++) begin
         s_ack = 1'b1;
         #1;
         check("t4_beat_ack", a2m_ack_o, 3'b100);
         check("t4_beat_grant", grant_o, 3'b100);
         tick();
      end
      s_ack = 1'b0;
      cyc = 3'b001; stb = 3'b001;
      #1;
      check("t4_drop_cycle", grant_o, 3'b100);
      tick();
      check("t4_idle", grant_o, 3'b000);
      tick();
      check("t4_grant0", grant_o, 3'b001);

      // Watchdog abort after TO unanswered strobes.
      do_reset();
      cyc = 3'b001; stb = 3'b001;
      tick();
      stb_cnt = 0;
      got_err = 1'b0;
      for (int c = 0; c < 40 && !got_err; c++) begin
         #1;
         if (a2m_err_o != '0) begin
            got_err = 1'b1;
         end else begin
            if (a2s_stb_o) stb_cnt++;
            tick();
         end
      end
      check("t5_stb_cycles", stb_cnt, TO);
      check("t5_err", a2m_err_o, 3'b001);
      check("t5_abort_cyc", a2s_cyc_o, 1'b0);
      check("t5_abort_stb", a2s_stb_o, 1'b0);
      cyc = '0; stb = '0;
      tick();
      check("t5_idle_grant", grant_o, 3'b000);
      check("t5_err_once", a2m_err_o, 3'b000);

      // Ack arriving in the expiry cycle wins over the watchdog.
      do_reset();
      cyc = 3'b001; stb = 3'b001;
      tick();
      repeat (TO - 1) tick();
      s_ack = 1'b1;
      #1;
      check("t6_ack", a2m_ack_o, 3'b001);
      check("t6_no_err", a2m_err_o, 3'b000);
      tick();
      s_ack = 1'b0;
      #1;
      check("t6_still_busy", grant_o, 3'b001);
      check("t6_still_cyc", a2s_cyc_o, 1'b1);
      check("t6_no_err_after", a2m_err_o, 3'b000);

      // Randomized traffic with quiet-slave windows to hit the watchdog.
      do_reset();
      begin
         bit silent;
         silent = 1'b0;
         for (int c = 0; c < 3000; c++) begin
            if (c % 60 == 0) silent = ($urandom_range(0, 2) == 0);
            for (int k = 0; k < N; k++) begin
               if (bit_at(cyc, k)) begin
                  if ($urandom_range(0, 15) == 0) cyc = cyc & ~(N'(1) << k);
               end else begin
                  if ($urandom_range(0, 4) == 0) cyc = cyc | (N'(1) << k);
               end
            end
            stb = '0;
            for (int k = 0; k < N; k++) begin
               if ($urandom_range(0, 19) < 17) stb = stb | (N'(1) << k);
            end
            stb  = stb & cyc;
            we   = N'($urandom);
            adr  = {$urandom, $urandom, $urandom};
            wdat = {$urandom, $urandom, $urandom};
            sel  = N*SW'($urandom);
            s_ack = silent ? 1'b0 : 1'($urandom_range(0, 1));
            s_err = silent ? 1'b0 : ($urandom_range(0, 19) == 0);
            s_dat = $urandom;
            tick();
         end
      end

      clear_inputs();
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
